// File: rtl/palette_layer_scheduler.sv
// palette_layer_scheduler
// Resolves one RGB888 pixel per unique (x,y) request. Layers are walked
// front-to-back through the palette pipeline port, stopping at the first
// non-transparent hit. The walk falls back to bg_rgb when no layer hits.
// Palette controller accesses are serialised between pixels.
// Optional build macro: PALSCHED_STATS_EN (background / duplicate counters).
module palette_layer_scheduler #(
    parameter int NUM_LAYERS = 32,
    parameter int POS_W      = 11,
    parameter int RD_LAT     = 1
) (
    input  logic             clk_pipe,
    input  logic             rst,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [POS_W-1:0] pix_x,
    input  logic [POS_W-1:0] pix_y,
    input  logic [5:0]       layer_count,
    input  logic [23:0]      bg_rgb,
    output logic [4:0]       idx_layer,
    input  logic [4:0]       idx_color,
    output logic [4:0]       pal_pipeLayer,
    output logic [4:0]       pal_pipeColor,
    input  logic [23:0]      pal_pipeRGB,
    input  logic             pal_pixelFound,
    input  logic             ctrl_req,
    input  logic             ctrl_we,
    input  logic [4:0]       ctrl_layer,
    input  logic [4:0]       ctrl_color,
    input  logic             ctrl_rgb,
    input  logic [15:0]      ctrl_wdata,
    output logic             ctrl_ack,
    output logic [15:0]      ctrl_rdata,
    output logic             pal_writeEn,
    output logic [4:0]       pal_ctrlLayer,
    output logic [4:0]       pal_ctrlColor,
    output logic             pal_ctrlRGB,
    output logic [15:0]      pal_ctrlWData,
    input  logic [15:0]      pal_ctrlRData,
`ifdef PALSCHED_STATS_EN
    input  logic             stat_clr,
    output logic [15:0]      stat_bg,
    output logic [15:0]      stat_dup,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [23:0]      out_rgb,
    output logic [POS_W-1:0] out_x,
    output logic [POS_W-1:0] out_y
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, CTRL} state_t;

    localparam logic [5:0] MAX_LAYERS = 6'(NUM_LAYERS);
    localparam logic [1:0] WAIT_LAST  = 2'(RD_LAT - 1);
    localparam logic [1:0] CTRL_LAST  = 2'(RD_LAT);

    state_t           state, state_d;
    logic [1:0]       cnt;
    logic [4:0]       layer_q;
    logic [4:0]       color_q;
    logic [23:0]      rgb_q;
    logic [POS_W-1:0] cur_x, cur_y;
    logic [POS_W-1:0] last_x, last_y;
    logic             last_vld;
    logic             ctrl_block;

    logic [5:0]       eff_count;
    logic             last_layer;
    logic             dup;
    logic             ready_c;
    logic             drop, walk_go, bg_go, hit, miss_end, step, done;

    // Over-range layer counts clamp; the count is re-read every time it is used.
    assign eff_count  = (layer_count > MAX_LAYERS) ? MAX_LAYERS : layer_count;
    // ">=" rather than "==" so a count lowered mid-walk still terminates.
    assign last_layer = ({1'b0, layer_q} + 6'd1) >= eff_count;
    assign dup        = last_vld && (pix_x == last_x) && (pix_y == last_y);

    // Pipeline-side palette address; kept apart from the FSM so the
    // combinational idx_layer -> idx_color return path forms no loop.
    assign idx_layer     = (state == ISSUE) ? layer_q : 5'd0;
    assign pal_pipeLayer = (state == ISSUE || state == WAIT) ? layer_q : 5'd0;
    assign pal_pipeColor = (state == ISSUE) ? idx_color :
                           (state == WAIT)  ? color_q   : 5'd0;

    assign pix_ready = ready_c && !rst;
    assign out_valid = (state == EMIT);
    assign out_rgb   = rgb_q;
    assign out_x     = cur_x;
    assign out_y     = cur_y;

    // State register.
    always_ff @(posedge clk_pipe or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state decode, handshake strobes and controller-port drive.
    always_comb begin
        state_d       = state;
        ready_c       = 1'b0;
        drop          = 1'b0;
        walk_go       = 1'b0;
        bg_go         = 1'b0;
        hit           = 1'b0;
        miss_end      = 1'b0;
        step          = 1'b0;
        done          = 1'b0;
        ctrl_ack      = 1'b0;
        ctrl_rdata    = 16'd0;
        pal_writeEn   = 1'b0;
        pal_ctrlLayer = 5'd0;
        pal_ctrlColor = 5'd0;
        pal_ctrlRGB   = 1'b0;
        pal_ctrlWData = 16'd0;
        unique case (state)
            IDLE: begin
                // After a controller access the next waiting pixel goes
                // first; the controller is still served when no pixel waits.
                ready_c = !ctrl_req || ctrl_block;
                if (ctrl_req && (!ctrl_block || !pix_valid)) begin
                    state_d = CTRL;
                end else if (pix_valid) begin
                    if (dup) begin
                        drop = 1'b1;
                    end else if (eff_count == 6'd0) begin
                        bg_go   = 1'b1;
                        state_d = EMIT;
                    end else begin
                        walk_go = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (cnt == WAIT_LAST) begin
                    if (pal_pixelFound) begin
                        hit     = 1'b1;
                        state_d = EMIT;
                    end else if (last_layer) begin
                        miss_end = 1'b1;
                        state_d  = EMIT;
                    end else begin
                        step    = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            CTRL: begin
                pal_ctrlLayer = ctrl_layer;
                pal_ctrlColor = ctrl_color;
                pal_ctrlRGB   = ctrl_rgb;
                pal_ctrlWData = ctrl_wdata;
                pal_writeEn   = ctrl_we && (cnt == 2'd0);
                if (cnt == CTRL_LAST) begin
                    ctrl_ack   = 1'b1;
                    ctrl_rdata = ctrl_we ? 16'd0 : pal_ctrlRData;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Walk datapath: cycle counter, layer/colour capture, result and history.
    always_ff @(posedge clk_pipe or posedge rst) begin
        if (rst) begin
            cnt        <= 2'd0;
            layer_q    <= 5'd0;
            color_q    <= 5'd0;
            rgb_q      <= 24'd0;
            cur_x      <= '0;
            cur_y      <= '0;
            last_x     <= '0;
            last_y     <= '0;
            last_vld   <= 1'b0;
            ctrl_block <= 1'b0;
        end else begin
            if (state_d != state)                   cnt <= 2'd0;
            else if (state == WAIT || state == CTRL) cnt <= cnt + 2'd1;

            if (walk_go || bg_go) begin
                cur_x <= pix_x;
                cur_y <= pix_y;
            end

            if (walk_go)     layer_q <= 5'd0;
            else if (step)   layer_q <= layer_q + 5'd1;

            if (state == ISSUE) color_q <= idx_color;

            if (bg_go || miss_end) rgb_q <= bg_rgb;
            else if (hit)          rgb_q <= pal_pipeRGB;

            if (done) begin
                last_x   <= cur_x;
                last_y   <= cur_y;
                last_vld <= 1'b1;
            end

            if (state == CTRL && state_d == IDLE) ctrl_block <= 1'b1;
            else if (done || drop)                ctrl_block <= 1'b0;
        end
    end

`ifdef PALSCHED_STATS_EN
    // Saturating event counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk_pipe or posedge rst) begin
        if (rst) begin
            stat_bg  <= 16'd0;
            stat_dup <= 16'd0;
        end else if (stat_clr) begin
            stat_bg  <= 16'd0;
            stat_dup <= 16'd0;
        end else begin
            if ((bg_go || miss_end) && stat_bg != 16'hFFFF) stat_bg <= stat_bg + 16'd1;
            if (drop && stat_dup != 16'hFFFF)              stat_dup <= stat_dup + 16'd1;
        end
    end
`endif

endmodule

// File: doc/palette_layer_scheduler.md
Name: palette_layer_scheduler

Overview:
- Sequences the palette lookup stage for each pixel.
- Walks layers front-to-back (layer 0 = front), presents each layer's colour index to the palette memory, and stops at the first non-transparent hit. If no layer hits, it substitutes the background colour.
- Emits one RGB888 pixel per unique (x,y), suppressing repeat coordinates.
- Arbitrates the palette controller port so register reads/writes from the controller only land between pixels, never mid-walk.

Parameters:
- NUM_LAYERS, 32, maximum layers walked; layer index width is 5.
- POS_W, 11, pixel coordinate width.
- RD_LAT, 1, palette read latency in cycles (1..3).

Ports:
- clk_pipe  in  1  pipeline clock
- rst  in  1  asynchronous reset, active-high
- pix_valid  in  1  pixel request valid
- pix_ready  out  1  pixel request accepted
- pix_x  in  POS_W  request x
- pix_y  in  POS_W  request y
- layer_count  in  6  active layers, 0..NUM_LAYERS; values above NUM_LAYERS clamp to NUM_LAYERS
- bg_rgb  in  24  background colour
- idx_layer  out  5  layer whose colour index is requested from the fetch stage
- idx_color  in  5  colour index for idx_layer, valid combinationally the same cycle
- pal_pipeLayer  out  5  palette pipeline read layer
- pal_pipeColor  out  5  palette pipeline read colour
- pal_pipeRGB  in  24  palette read data, RD_LAT cycles after address
- pal_pixelFound  in  1  1 = non-transparent, aligned with pal_pipeRGB
- ctrl_req  in  1  controller access request, held until ctrl_ack
- ctrl_we  in  1  1 = write
- ctrl_layer  in  5  controller layer
- ctrl_color  in  5  controller colour slot
- ctrl_rgb  in  1  controller RGB select
- ctrl_wdata  in  16  controller write data
- ctrl_ack  out  1  one-cycle completion pulse
- ctrl_rdata  out  16  read data, valid with ctrl_ack
- pal_writeEn, pal_ctrlLayer, pal_ctrlColor, pal_ctrlRGB, pal_ctrlWData  out  1/5/5/1/16  palette controller port
- pal_ctrlRData  in  16  palette controller read data
- out_valid  out  1  pixel output valid
- out_ready  in  1  downstream accept
- out_rgb  out  24  resolved colour
- out_x, out_y  out  POS_W  coordinates of out_rgb

Behaviour:
- Reset (async, immediate): state IDLE; every output 0; last-coordinate-valid flag cleared; any in-flight controller access is aborted with no ack.
- States: IDLE, ISSUE, WAIT, EMIT, CTRL.
- IDLE:
  - ctrl_req has priority: go to CTRL, pix_ready=0.
  - Otherwise pix_ready=1. On pix_valid, latch x,y.
  - If last-valid and (x,y)==last emitted: drop the request, stay IDLE.
  - Else if layer_count==0: out_rgb=bg_rgb, go to EMIT.
  - Else layer=0, go to ISSUE.
- ISSUE (1 cycle):
  - idx_layer=layer.
  - pal_pipeLayer=layer, pal_pipeColor=idx_color (combinational); idx_color is captured into a register.
  - Go to WAIT.
- WAIT (RD_LAT cycles):
  - pal_pipeLayer/pal_pipeColor held from the registers.
  - On the last WAIT cycle sample pal_pixelFound:
    - 1: out_rgb=pal_pipeRGB, go to EMIT.
    - 0 and layer==layer_count-1: out_rgb=bg_rgb, go to EMIT.
    - 0 otherwise: layer+1, go to ISSUE.
- EMIT:
  - out_valid=1; out_rgb/out_x/out_y are stable until accepted.
  - On out_ready: store last=(x,y), set last-valid, go to IDLE. No new request is accepted in the handshake cycle.
- Latency, RD_LAT=1, hit at layer k: out_valid rises 3+2k cycles after the pix_valid&pix_ready cycle. All-transparent with N layers: 1+2N cycles. layer_count==0: 1 cycle.
- CTRL (RD_LAT+1 cycles):
  - Palette ctrl port driven from ctrl_* for the whole state.
  - pal_writeEn=ctrl_we on the first cycle only.
  - Last cycle: ctrl_ack=1, ctrl_rdata=pal_ctrlRData (writes return don't-care, driven 0). Then go to IDLE.
- Coherency: layer_count and bg_rgb are sampled on each use. Controller writes never overlap a pixel walk.
- Fairness: worst-case ctrl_req wait is one pixel walk plus EMIT backpressure. A pixel waits at most one CTRL access, because ctrl_req is only rechecked after a pixel completes (IDLE entered from EMIT or drop).
- Palette ports are all 0 when not in the owning state.

Optional Feature:
PALSCHED_STATS_EN
- Defined: adds outputs stat_bg (16), stat_dup (16) and input stat_clr (1).
  - stat_bg counts emitted background pixels.
  - stat_dup counts dropped duplicates.
  - Both counters are saturating at 0xFFFF, cleared by rst or stat_clr; stat_clr has priority over a same-cycle increment.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- layer_count=4, layer 2 idx maps to found=1, RGB 0x12AB34 (RD_LAT=1) -> out_rgb=0x12AB34 exactly 7 cycles after accept; pal_pipeLayer sequence 0,1,2.
- layer_count=3, all transparent, bg_rgb=0x000080 -> out_rgb=0x000080 after 7 cycles; layer 3 never addressed.
- Same (x,y)=(100,50) requested twice -> one output; second request accepted with pix_ready=1 and no out_valid; with PALSCHED_STATS_EN, stat_dup=1.
- ctrl_req write (layer 5, colour 7, rgb 0, data 0xF800) asserted mid-walk -> pal_writeEn only after EMIT handshake; ctrl_ack RD_LAT+1 cycles after CTRL entry; subsequent read of the same slot returns 0xF800.
- out_ready held low 10 cycles in EMIT -> out_rgb/out_x/out_y stable, pix_ready=0 throughout.
- rst asserted during WAIT and during CTRL -> outputs 0 immediately, no ctrl_ack; next identical (x,y) is emitted, since last-valid was cleared.
